cpu_axi_master: RTL and testbench

- Bridge between one CPU memory port (IM or DM) and an AXI4 master interface; the wrapper instantiates it twice, once for IM and once for DM.
- Takes single-beat read/write requests from the pipeline and issues single-beat AXI bursts (ARLEN/AWLEN = 0).
- Generates cpu_stall, which freezes all pipeline registers until the transaction completes.
- Returns read data on the cycle the stall drops.

---
 rtl/cpu_axi_pkg.sv | 29 ++
 rtl/cpu_axi_master_if.sv | 67 ++++++
 rtl/cpu_axi_master_strb_gen.sv | 27 ++
 rtl/cpu_axi_master.sv | 166 ++++++++++++++++
 tb/tb_cpu_axi_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared types and encodings for the CPU-to-AXI4 single-beat bridge.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [2:0] CORE_WORD = 3'd0;
  localparam logic [2:0] CORE_HALF = 3'd1;
  localparam logic [2:0] CORE_BYTE = 3'd2;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'd0;
  localparam logic [2:0] AXI_SIZE_HALF = 3'd1;
  localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/cpu_axi_master_if.sv
// AXI4 channel bundle between cpu_axi_master and its slave.
interface cpu_axi_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cpu_axi_master_strb_gen.sv
// Maps CPU access size and low address bits to AXI size and write strobes.
module axi_strb_gen
  import cpu_axi_pkg::*;
(
  input  logic [2:0] core_type,
  input  logic [1:0] addr_lo,
  output logic [2:0] size,
  output logic [3:0] strb
);

  always_comb begin
    size = AXI_SIZE_WORD;
    strb = 4'b1111;
    case (core_type)
      CORE_HALF: begin
        size = AXI_SIZE_HALF;
        strb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      CORE_BYTE: begin
        size = AXI_SIZE_BYTE;
        strb = 4'b0001 << addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_axi_master.sv
// Single-beat CPU memory port to AXI4 master bridge with pipeline stall.
// Define AXI_TIMEOUT_EN to add a watchdog that aborts stuck transfers.
module cpu_axi_master
  import cpu_axi_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ID_W           = 4,
  parameter int unsigned MASTER_ID      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [2:0]           req_core_type,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err,
  output logic                 cpu_stall,
  cpu_axi_master_if.master     axi
);

  state_t              state_q, state_n;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          strb_q;
  logic [2:0]          size_q;
  logic [2:0]          gen_size;
  logic [3:0]          gen_strb;
  logic                timeout;
  logic                unused_ok;

  axi_strb_gen u_strb_gen (
    .core_type (req_core_type),
    .addr_lo   (req_addr[1:0]),
    .size      (gen_size),
    .strb      (gen_strb)
  );

`ifdef AXI_TIMEOUT_EN
  localparam int unsigned WDOG_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WDOG_W-1:0] wdog_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wdog_q <= '0;
    else if (state_q == ST_IDLE || state_q == ST_DONE)
      wdog_q <= '0;
    else
      wdog_q <= wdog_q + 1'b1;
  end

  assign timeout = (state_q != ST_IDLE) && (state_q != ST_DONE) &&
                   (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
  assign unused_ok = ^{axi.rid, axi.rlast, axi.bid};
`else
  assign timeout   = 1'b0;
  assign unused_ok = ^{axi.rid, axi.rlast, axi.bid, (TIMEOUT_CYCLES != 0)};
`endif

  assign axi.arid    = ID_W'(MASTER_ID);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = size_q;
  assign axi.arburst = BURST_INCR;

  assign axi.awid    = ID_W'(MASTER_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = size_q;
  assign axi.awburst = BURST_INCR;

  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = strb_q;
  assign axi.wlast   = 1'b1;

  always_comb begin
    state_n     = state_q;
    cpu_stall   = 1'b1;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_stall = req_read | req_write;
        if (req_write)
          state_n = ST_AWW;
        else if (req_read)
          state_n = ST_AR;
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_n = ST_R;
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_n = ST_DONE;
      end
      // AW and W may complete in either order; the leftover channel gets its own state
      ST_AWW: begin
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        if (axi.awready && axi.wready)
          state_n = ST_B;
        else if (axi.awready)
          state_n = ST_W;
        else if (axi.wready)
          state_n = ST_AW;
      end
      ST_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_n = ST_B;
      end
      ST_W: begin
        axi.wvalid = 1'b1;
        if (axi.wready) state_n = ST_B;
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_n = ST_DONE;
      end
      ST_DONE: begin
        cpu_stall = 1'b0;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (timeout) state_n = ST_DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      size_q     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == ST_IDLE && (req_read || req_write)) begin
        addr_q  <= req_addr;
        size_q  <= gen_size;
        wdata_q <= req_wdata;
        strb_q  <= gen_strb;
      end
      if (timeout) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end else if (state_q == ST_R && axi.rvalid) begin
        resp_rdata <= axi.rdata;
        resp_err   <= (axi.rresp != RESP_OKAY);
      end else if (state_q == ST_B && axi.bvalid) begin
        resp_err <= (axi.bresp != RESP_OKAY);
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Randomized transaction-level bench for cpu_axi_master with a reactive AXI slave.
module tb_cpu_axi_master;

  localparam int unsigned TMO    = 16;
  localparam int unsigned BUDGET = 64;
  localparam logic [3:0]  MID    = 4'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_core_type = '0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        cpu_stall;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] last_rd = '0;

  cpu_axi_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  cpu_axi_master #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MASTER_ID(5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_read      (req_read),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_core_type (req_core_type),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .cpu_stall     (cpu_stall),
    .axi           (axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_size(input logic [2:0] ct);
    if (ct == 3'd1) return 3'd1;
    if (ct == 3'd2) return 3'd0;
    return 3'd2;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] ct, input logic [31:0] a);
    int unsigned off;
    off = a % 4;
    if (ct == 3'd2) return 4'(1 << off);
    if (ct == 3'd1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  task automatic slave_quiet();
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.rdata   = $urandom;
    axi.rresp   = 2'($urandom);
    axi.rid     = 4'($urandom);
    axi.rlast   = 1'b0;
    axi.bresp   = 2'($urandom);
    axi.bid     = 4'($urandom);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_read  = 1'b0;
    req_write = 1'b0;
    #1;
    check("idle_stall", cpu_stall, 0);
    check("idle_outs", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
  endtask

  // Read: w0 = AR wait, w1 = R wait. Write: w0 = AW wait, w1 = W wait, w2 = B wait.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] ct, input int unsigned w0, input int unsigned w1,
                        input int unsigned w2, input logic [1:0] resp, input logic [31:0] rd);
    logic [2:0]  esz;
    logic [3:0]  estrb;
    int unsigned c0, c1, c2, cyc;
    bit          a_done, d_done, fin;
    esz   = exp_size(ct);
    estrb = exp_strb(ct, addr);
    @(negedge clk);
    req_read      = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    req_write     = wr;
    req_addr      = addr;
    req_wdata     = wd;
    req_core_type = ct;
    #1;
    check("req_stall", cpu_stall, 1);
    check("req_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
    a_done = 0; d_done = 0; fin = 0;
    c0 = 0; c1 = 0; c2 = 0; cyc = 0;
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      req_addr      = $urandom;
      req_wdata     = $urandom;
      req_core_type = 3'($urandom);
      slave_quiet();
      #1;
      cyc++;
      check("busy_stall", cpu_stall, 1);
      if (!wr) begin
        check("rd_no_wr", {axi.awvalid, axi.wvalid, axi.bready}, 0);
        if (!a_done) begin
          check("ar_phase", {axi.arvalid, axi.rready}, 2'b10);
          check("ar_addr", axi.araddr, addr);
          check("ar_ctl", {axi.arid, axi.arlen, axi.arsize, axi.arburst}, {MID, 4'd0, esz, 2'b01});
          if (c0 >= w0) begin axi.arready = 1'b1; a_done = 1; end
          c0++;
        end else begin
          check("r_phase", {axi.arvalid, axi.rready}, 2'b01);
          if (c1 >= w1) begin
            axi.rvalid = 1'b1; axi.rdata = rd; axi.rresp = resp; axi.rlast = 1'b1;
            fin = 1;
          end
          c1++;
        end
      end else begin
        check("wr_no_rd", {axi.arvalid, axi.rready}, 0);
        if (!(a_done && d_done)) begin
          check("aw_w_phase", {axi.awvalid, axi.wvalid, axi.bready}, {!a_done, !d_done, 1'b0});
          if (!a_done) begin
            check("aw_addr", axi.awaddr, addr);
            check("aw_ctl", {axi.awid, axi.awlen, axi.awsize, axi.awburst}, {MID, 4'd0, esz, 2'b01});
            if (c0 >= w0) begin axi.awready = 1'b1; a_done = 1; end
          end
          if (!d_done) begin
            check("w_data", axi.wdata, wd);
            check("w_ctl", {axi.wstrb, axi.wlast}, {estrb, 1'b1});
            if (c1 >= w1) begin axi.wready = 1'b1; d_done = 1; end
          end
          c0++; c1++;
        end else begin
          check("b_phase", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
          if (c2 >= w2) begin axi.bvalid = 1'b1; axi.bresp = resp; fin = 1; end
          c2++;
        end
      end
    end
    if (!fin) begin
      check("txn_budget", cyc, BUDGET + 1);
      return;
    end
    @(negedge clk);
    slave_quiet();
    #1;
    if (!wr) last_rd = rd;
    check("done_stall", cpu_stall, 0);
    check("done_outs", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    check("done_err", resp_err, (resp != 2'b00));
    check("done_rdata", resp_rdata, last_rd);
  endtask

  initial begin
    slave_quiet();
    #1;
    check("rst_outs", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    check("rst_resp", {resp_err, resp_rdata}, 0);
    check("rst_stall", cpu_stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    do_txn(0, 32'h0000_0010, 32'h0, 3'd0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
    do_txn(1, 32'h0001_0003, 32'hAB00_0000, 3'd2, 0, 0, 0, 2'b00, 32'h0);
    do_txn(1, 32'h0000_0020, 32'h1234_5678, 3'd0, 0, 4, 0, 2'b00, 32'h0);
    do_txn(1, 32'h0000_0026, 32'h5A5A_0000, 3'd1, 3, 0, 1, 2'b00, 32'h0);
    do_txn(0, 32'h0000_0030, 32'h0, 3'd0, 1, 1, 0, 2'b10, 32'hCAFE_F00D);
    do_txn(0, 32'h0000_0034, 32'h0, 3'd0, 0, 2, 0, 2'b00, 32'h0BAD_CAFE);

    // abandon a read while in the data phase
    @(negedge clk);
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_core_type = 3'd0;
    @(negedge clk);
    #1;
    axi.arready = 1'b1;
    @(negedge clk);
    #1;
    axi.arready = 1'b0;
    check("pre_rst_r", {axi.arvalid, axi.rready}, 2'b01);
    rst = 1'b1;
    req_read = 1'b0;
    #1;
    check("mid_rst_outs", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
    check("mid_rst_stall", cpu_stall, 0);
    check("mid_rst_resp", {resp_err, resp_rdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    do_txn(0, 32'h0000_0104, 32'h0, 3'd0, 0, 0, 0, 2'b00, 32'h1357_9BDF);

    for (int unsigned i = 0; i < 150; i++) begin
      logic [1:0] rsp;
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      do_txn(1'($urandom), $urandom, $urandom, 3'($urandom_range(0, 4)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             rsp, $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

`ifdef AXI_TIMEOUT_EN
    begin
      int unsigned n_ar;
      n_ar = 0;
      @(negedge clk);
      slave_quiet();
      req_read = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_core_type = 3'd0;
      for (int unsigned i = 0; i < 100; i++) begin
        @(negedge clk);
        #1;
        if (!axi.arvalid) break;
        n_ar++;
      end
      check("tmo_cycles", n_ar, TMO);
      check("tmo_stall_err", {cpu_stall, resp_err}, 2'b01);
      check("tmo_rdata", resp_rdata, 0);
      last_rd = '0;
    end
`endif

    idle_cycle();
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
